// File: rtl/adder_result_collector.sv
// Result collector behind a fixed-latency pipelined adder: tracks issues with a
// valid/tag pipe, captures {carry, sum} into a FIFO, and gates issue by credits.
module adder_result_collector #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 5,
    parameter int DEPTH   = 4,
    parameter int TAGW    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         sum_in,
    input  logic                     cout_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH:0]           out_data,
    output logic [TAGW-1:0]          out_tag,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               stall_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [LATENCY-1:0]            vld_pipe;
    logic [LATENCY-1:0][TAGW-1:0]  tag_pipe;
    logic [DEPTH-1:0][WIDTH:0]     data_mem;
    logic [DEPTH-1:0][TAGW-1:0]    tag_mem;
    logic [AW-1:0]                 wr_ptr;
    logic [AW-1:0]                 rd_ptr;
    logic [CW-1:0]                 inflight;
    logic [TAGW-1:0]               issue_tag;
    logic [CW:0]                   credits_used;
    logic                          accept;
    logic                          capture;
    logic                          pop;

    // Every issued operand owns a FIFO slot from issue until pop, so a capture
    // always finds room and the adder never needs to stall.
    assign credits_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign in_ready     = credits_used < (CW+1)'(DEPTH);

    assign accept    = in_valid && in_ready;
    assign capture   = vld_pipe[LATENCY-1];
    assign out_valid = fifo_count != '0;
    assign pop       = out_valid && out_ready;
    assign out_data  = data_mem[rd_ptr];
    assign out_tag   = tag_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[0] <= accept;
            tag_pipe[0] <= issue_tag;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_tag <= '0;
            inflight  <= '0;
        end else begin
            if (accept)
                issue_tag <= issue_tag + TAGW'(1);
            case ({accept, capture})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_mem   <= '0;
            tag_mem    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (capture) begin
                data_mem[wr_ptr] <= {cout_in, sum_in};
                tag_mem[wr_ptr]  <= tag_pipe[LATENCY-1];
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (in_valid && !in_ready && stall_cnt != 8'hFF)
            stall_cnt <= stall_cnt + 8'd1;
    end

endmodule
